// File: rtl/seg7_pkg.sv
// Shared constants for the HH:MM:SS seven-segment timer: segment patterns
// in {dp,g,f,e,d,c,b,a} order (active-high) and the time-field limits.
package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Per-digit limits derived from the field maxima.
    localparam logic [3:0] UNITS_MAX     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'(SEC_MAX / 10);
    localparam logic [3:0] MIN_TENS_MAX  = 4'(MIN_MAX / 10);
    localparam logic [3:0] HOUR_TENS_MAX = 4'(HOUR_MAX / 10);
    localparam logic [3:0] HOUR_LAST_U   = 4'(HOUR_MAX % 10);

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes blank.
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_timer_hms.sv
// 24-hour HH:MM:SS timer: tick prescaler, six BCD digit registers with a
// ripple carry chain, and one combinational segment decoder per digit.
module seven_seg_timer_hms
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] sec0,
    output logic [7:0] sec1,
    output logic [7:0] min0,
    output logic [7:0] min1,
    output logic [7:0] hour0,
    output logic [7:0] hour1
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    logic [3:0] s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
    logic [3:0] s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
    logic       c_s0, c_s1, c_m0, c_m1, day_wrap;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Each carry means "this digit is wrapping on this tick".
    assign c_s0     = tick & (s0_q == UNITS_MAX);
    assign c_s1     = c_s0 & (s1_q == SEC_TENS_MAX);
    assign c_m0     = c_s1 & (m0_q == UNITS_MAX);
    assign c_m1     = c_m0 & (m1_q == MIN_TENS_MAX);
    assign day_wrap = c_m1 & (h1_q == HOUR_TENS_MAX) & (h0_q == HOUR_LAST_U);

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        m0_d = m0_q;
        m1_d = m1_q;
        h0_d = h0_q;
        h1_d = h1_q;
        if (tick) s0_d = c_s0 ? 4'd0 : s0_q + 4'd1;
        if (c_s0) s1_d = c_s1 ? 4'd0 : s1_q + 4'd1;
        if (c_s1) m0_d = c_m0 ? 4'd0 : m0_q + 4'd1;
        if (c_m0) m1_d = c_m1 ? 4'd0 : m1_q + 4'd1;
        if (c_m1) begin
            if (day_wrap) begin
                h0_d = 4'd0;
                h1_d = 4'd0;
            end else if (h0_q == UNITS_MAX) begin
                h0_d = 4'd0;
                h1_d = h1_q + 4'd1;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            m0_q    <= 4'd0;
            m1_q    <= 4'd0;
            h0_q    <= 4'd0;
            h1_q    <= 4'd0;
        end else begin
            presc_q <= presc_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            m0_q    <= m0_d;
            m1_q    <= m1_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
        end
    end

    bcd_to_7seg u_dec_s0 (.digit_i(s0_q), .seg_o(sec0));
    bcd_to_7seg u_dec_s1 (.digit_i(s1_q), .seg_o(sec1));
    bcd_to_7seg u_dec_m0 (.digit_i(m0_q), .seg_o(min0));
    bcd_to_7seg u_dec_m1 (.digit_i(m1_q), .seg_o(min1));
    bcd_to_7seg u_dec_h0 (.digit_i(h0_q), .seg_o(hour0));
    bcd_to_7seg u_dec_h1 (.digit_i(h1_q), .seg_o(hour1));

endmodule

// File: tb/tb_seven_seg_timer_hms.sv
// Directed bench for the HH:MM:SS timer: one instance at one tick per clk and
// one with a divide-by-4 prescaler, both shadowed by a seconds-count model.
module tb_seven_seg_timer_hms;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] sec0, sec1, min0, min1, hour0, hour1;
    logic [7:0] b_sec0, b_sec1, b_min0, b_min1, b_hour0, b_hour1;

    seven_seg_timer_hms u_dut (
        .clk   (clk),
        .resetn(resetn),
        .sec0  (sec0),
        .sec1  (sec1),
        .min0  (min0),
        .min1  (min1),
        .hour0 (hour0),
        .hour1 (hour1)
    );

    seven_seg_timer_hms #(.TICKS_PER_SEC(4)) u_dut4 (
        .clk   (clk),
        .resetn(resetn),
        .sec0  (b_sec0),
        .sec1  (b_sec1),
        .min0  (b_min0),
        .min1  (b_min1),
        .hour0 (b_hour0),
        .hour1 (b_hour1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: elapsed seconds since reset for each instance.
    int model_s  = 0;
    int model_s4 = 0;
    int model_p4 = 0;

    logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic logic [47:0] enc_time(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10],
                seg_tab[m % 10], seg_tab[s / 10], seg_tab[s % 10]};
    endfunction

    function automatic logic [47:0] disp_a();
        return {hour1, hour0, min1, min0, sec1, sec0};
    endfunction

    function automatic logic [47:0] disp_b();
        return {b_hour1, b_hour0, b_min1, b_min0, b_sec1, b_sec0};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One posedge; update the model, then compare both instances at negedge.
    task automatic clk_step();
        @(posedge clk);
        if (!resetn) begin
            model_s  = 0;
            model_s4 = 0;
            model_p4 = 0;
        end else begin
            model_s = (model_s + 1) % 86400;
            if (model_p4 == 3) begin
                model_p4 = 0;
                model_s4 = (model_s4 + 1) % 86400;
            end else begin
                model_p4++;
            end
        end
        @(negedge clk);
        check("model_tps1", disp_a(), enc_time(model_s));
        check("model_tps4", disp_b(), enc_time(model_s4));
    endtask

    initial begin
        resetn = 1'b0;
        clk_step();
        check("reset_tps1", disp_a(), {6{8'h3F}});
        check("reset_tps4", disp_b(), {6{8'h3F}});

        resetn = 1'b1;
        repeat (10) clk_step();
        check("t00_00_10", {32'h0, sec1, sec0}, {32'h0, 8'h06, 8'h3F});

        repeat (27) clk_step();
        check("t00_00_37", {32'h0, sec1, sec0}, {32'h0, 8'h4F, 8'h07});
        check("div4_at37", {40'h0, b_sec0}, {40'h0, 8'h6F});

        resetn = 1'b0;
        clk_step();
        check("midreset_tps1", disp_a(), {6{8'h3F}});
        check("midreset_tps4", disp_b(), {6{8'h3F}});

        resetn = 1'b1;
        repeat (3) clk_step();
        check("div4_hold", {40'h0, b_sec0}, {40'h0, 8'h3F});
        check("tps1_at3", {40'h0, sec0}, {40'h0, 8'h4F});
        clk_step();
        check("div4_step", {40'h0, b_sec0}, {40'h0, 8'h06});

        repeat (56) clk_step();
        check("t00_01_00", disp_a(), {8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h3F, 8'h3F});

        repeat (3540) clk_step();
        check("t01_00_00", disp_a(), {8'h3F, 8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F});

        repeat (86399 - 3600) clk_step();
        check("t23_59_59", disp_a(), {8'h5B, 8'h4F, 8'h6D, 8'h6F, 8'h6D, 8'h6F});

        clk_step();
        check("day_wrap", disp_a(), {6{8'h3F}});
        check("div4_t06_00_00", disp_b(), {8'h3F, 8'h7D, 8'h3F, 8'h3F, 8'h3F, 8'h3F});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
